tone_decoder: RTL and testbench

- Receive-side counterpart of the buzzer tone generator. Watches a buzzer square wave in the 3.16 kHz game-clock domain and decides which tone was played: B4 (wall) or B5 (paddle).
- Measures each burst and reports it with a one-cycle done pulse.
- Used as an on-chip sound-event monitor/self-check and as the scoreboard front-end in the sound testbench.

---
 rtl/pong_sound_pkg.sv | 17 +
 rtl/sat_counter.sv | 39 +++
 rtl/tone_decoder.sv | 177 +++++++++++++++++
 tb/tb_tone_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pong_sound_pkg.sv
// Constants shared by the buzzer tone generator and the tone decoder.
package pong_sound_pkg;

    localparam int HALF_B4       = 4;
    localparam int HALF_B5       = 3;
    localparam int TONE_DURATION = 258;

    localparam logic TONE_B4 = 1'b0;
    localparam logic TONE_B5 = 1'b1;

    typedef enum logic [1:0] {
        DEC_IDLE  = 2'd0,
        DEC_LOCK  = 2'd1,
        DEC_TRACK = 2'd2
    } dec_state_e;

endpackage

// File: rtl/sat_counter.sv
// Counter with load, add-step and saturation at MAX; synchronous active-high reset to 0.
module sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] step_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {1'b0, step_i};
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = (sum > {1'b0, MAX}) ? MAX : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tone_decoder.sv
// Classifies buzzer bursts as B4 or B5 by measuring edge intervals; reports each burst with a done pulse.
//   state     | meaning
//   DEC_IDLE  | no burst, waiting for a first edge
//   DEC_LOCK  | one edge seen, second edge decides the tone
//   DEC_TRACK | tone classified, checking every further interval
module tone_decoder
    import pong_sound_pkg::*;
#(
    parameter int HALF_B4      = pong_sound_pkg::HALF_B4,
    parameter int HALF_B5      = pong_sound_pkg::HALF_B5,
    parameter int IDLE_TIMEOUT = 8,
    parameter int MIN_EDGES    = 4,
    parameter int CNT_W        = 8,
    parameter int SPAN_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buzzer_in,
    output logic              busy,
    output logic              done,
    output logic              tone_id,
    output logic [CNT_W-1:0]  edge_count,
    output logic [SPAN_W-1:0] span,
    output logic              error
);

    localparam int               GAP_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_B4  = GAP_W'(HALF_B4);
    localparam logic [GAP_W-1:0] GAP_B5  = GAP_W'(HALF_B5);

    dec_state_e        state_q;
    logic              buzzer_q;
    logic              buzzer_s;
    logic              edge_det;
    logic              in_burst;
    logic              timeout;
    logic              tone_q, tone_d;
    logic              mismatch_q, mismatch_d;
    logic              fin_err;
    logic [GAP_W-1:0]  gap;
    logic [CNT_W-1:0]  cnt;
    logic [SPAN_W-1:0] span_cnt;
    logic              res_tone_q, res_err_q;
    logic [CNT_W-1:0]  res_cnt_q;
    logic [SPAN_W-1:0] res_span_q;

    // An undriven (X) buzzer is read as low so the first real write is seen as an edge.
    assign buzzer_s = (buzzer_in === 1'b1);
    assign edge_det = buzzer_s ^ buzzer_q;
    assign in_burst = (state_q != DEC_IDLE);
    // Combinational so that an edge arriving on the timeout cycle still cancels the end of burst.
    assign timeout  = in_burst && !edge_det && (gap == GAP_MAX) && !reset;
    assign fin_err  = mismatch_q || (cnt < CNT_W'(MIN_EDGES));

    always_ff @(posedge clk) begin
        if (reset) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= buzzer_s;
        end
    end

    sat_counter #(.W(GAP_W), .MAX(GAP_MAX)) u_gap (
        .clk        (clk),
        .reset      (reset),
        .load_i     (edge_det),
        .load_val_i (GAP_W'(1)),
        .inc_i      (1'b1),
        .step_i     (GAP_W'(1)),
        .count_o    (gap)
    );

    sat_counter #(.W(CNT_W)) u_edge_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (edge_det && !in_burst),
        .load_val_i (CNT_W'(1)),
        .inc_i      (edge_det && in_burst),
        .step_i     (CNT_W'(1)),
        .count_o    (cnt)
    );

    sat_counter #(.W(SPAN_W)) u_span (
        .clk        (clk),
        .reset      (reset),
        .load_i     (edge_det && !in_burst),
        .load_val_i ('0),
        .inc_i      (edge_det && in_burst),
        .step_i     (SPAN_W'(gap)),
        .count_o    (span_cnt)
    );

    always_comb begin
        tone_d     = tone_q;
        mismatch_d = mismatch_q;
        if (edge_det) begin
            case (state_q)
                DEC_IDLE: begin
                    tone_d     = TONE_B4;
                    mismatch_d = 1'b0;
                end
                DEC_LOCK: begin
                    if (gap == GAP_B4) begin
                        tone_d = TONE_B4;
                    end else if (gap == GAP_B5) begin
                        tone_d = TONE_B5;
                    end else begin
                        tone_d     = TONE_B4;
                        mismatch_d = 1'b1;
                    end
                end
                DEC_TRACK: begin
                    if (gap != ((tone_q == TONE_B5) ? GAP_B5 : GAP_B4)) begin
                        mismatch_d = 1'b1;
                    end
                end
                default: begin
                    mismatch_d = mismatch_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DEC_IDLE;
            tone_q     <= 1'b0;
            mismatch_q <= 1'b0;
            res_tone_q <= 1'b0;
            res_err_q  <= 1'b0;
            res_cnt_q  <= '0;
            res_span_q <= '0;
        end else begin
            tone_q     <= tone_d;
            mismatch_q <= mismatch_d;
            case (state_q)
                DEC_IDLE: begin
                    if (edge_det) state_q <= DEC_LOCK;
                end
                DEC_LOCK: begin
                    if (edge_det)     state_q <= DEC_TRACK;
                    else if (timeout) state_q <= DEC_IDLE;
                end
                DEC_TRACK: begin
                    if (timeout) state_q <= DEC_IDLE;
                end
                default: state_q <= DEC_IDLE;
            endcase
            if (timeout) begin
                res_tone_q <= tone_q;
                res_err_q  <= fin_err;
                res_cnt_q  <= cnt;
                res_span_q <= span_cnt;
            end
        end
    end

    // Results are live on the done cycle and held from the result registers afterwards.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        tone_id    = 1'b0;
        edge_count = '0;
        span       = '0;
        error      = 1'b0;
        if (!reset) begin
            busy       = in_burst && !timeout;
            done       = timeout;
            tone_id    = timeout ? tone_q   : res_tone_q;
            edge_count = timeout ? cnt      : res_cnt_q;
            span       = timeout ? span_cnt : res_span_q;
            error      = timeout ? fin_err  : res_err_q;
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: bursts described as edge-interval lists, expectations derived from them.
module tb_tone_decoder;

    logic       clk;
    logic       reset;
    logic       buzzer_in;
    logic       busy, done, tone_id, error;
    logic [7:0] edge_count;
    logic [9:0] span;

    int checks = 0;
    int errors = 0;
    logic lvl;
    int ivl[$];
    int h_tone, h_cnt, h_span, h_err;

    tone_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .buzzer_in  (buzzer_in),
        .busy       (busy),
        .done       (done),
        .tone_id    (tone_id),
        .edge_count (edge_count),
        .span       (span),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string pfx);
        chk({pfx, "_tone"}, tone_id, h_tone);
        chk({pfx, "_cnt"}, edge_count, h_cnt);
        chk({pfx, "_span"}, span, h_span);
        chk({pfx, "_err"}, error, h_err);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        buzzer_in = lvl;
        #1;
    endtask

    // Plays one burst: first edge at local cycle 0, then edges after each interval in ivl.
    task automatic play(input int tail);
        int n, sum, half, tone, last;
        bit mis;
        int edges[$];
        int e_cnt, e_span, e_err;
        n    = ivl.size() + 1;
        sum  = 0;
        mis  = 0;
        tone = 0;
        edges.push_back(0);
        foreach (ivl[k]) begin
            sum += ivl[k];
            edges.push_back(sum);
        end
        last = sum;
        if (n >= 2) begin
            tone = (ivl[0] == 3) ? 1 : 0;
            half = tone ? 3 : 4;
            foreach (ivl[k]) if (ivl[k] != half) mis = 1;
        end
        e_cnt  = (n > 255) ? 255 : n;
        e_span = (sum > 1023) ? 1023 : sum;
        e_err  = (mis || n < 4) ? 1 : 0;
        for (int c = 0; c <= last + 8 + tail; c++) begin
            @(posedge clk);
            #1;
            if (edges.size() > 0 && edges[0] == c) begin
                lvl = ~lvl;
                void'(edges.pop_front());
            end
            buzzer_in = lvl;
            #1;
            chk("done", done, (c == last + 8));
            chk("busy", busy, (c >= 1 && c < last + 8));
            if (c == last + 8) begin
                chk("res_tone", tone_id, tone);
                chk("res_cnt", edge_count, e_cnt);
                chk("res_span", span, e_span);
                chk("res_err", error, e_err);
                h_tone = tone;
                h_cnt  = e_cnt;
                h_span = e_span;
                h_err  = e_err;
            end else if (c % 7 == 3) begin
                chk_held("hold");
            end
        end
    endtask

    initial begin
        int n;
        int base;
        lvl       = 1'b0;
        buzzer_in = 1'b0;
        reset     = 1'b1;
        h_tone = 0; h_cnt = 0; h_span = 0; h_err = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_held("rst");
        reset = 1'b0;
        repeat (2) tick();

        // Nominal B4: 64 edges every 4 cycles
        ivl.delete();
        repeat (63) ivl.push_back(4);
        play(3);

        // Nominal B5: 86 edges every 3 cycles
        ivl.delete();
        repeat (85) ivl.push_back(3);
        play(3);

        // B4 with one short (3) sixth interval
        ivl.delete();
        for (int k = 0; k < 9; k++) ivl.push_back((k == 5) ? 3 : 4);
        play(2);

        // Too few edges: two edges, then a lone edge
        ivl.delete();
        ivl.push_back(4);
        play(2);
        ivl.delete();
        play(2);

        // Reset at the 20th edge of a B4 burst discards it
        for (int c = 0; c <= 76; c++) begin
            @(posedge clk);
            #1;
            if (c % 4 == 0) lvl = ~lvl;
            buzzer_in = lvl;
            if (c == 76) reset = 1'b1;
            #1;
            chk("abort_done", done, 0);
            chk("abort_busy", busy, (c >= 1 && c < 76));
        end
        h_tone = 0; h_cnt = 0; h_span = 0; h_err = 0;
        chk_held("abort_rst");
        lvl = 1'b0;
        tick();
        chk("abort_rst_done", done, 0);
        reset = 1'b0;
        repeat (2) tick();
        chk("abort_idle_busy", busy, 0);
        chk_held("abort_clr");
        ivl.delete();
        repeat (11) ivl.push_back(3);
        play(4);

        // Interval exactly at the timeout continues the burst; next burst starts right after done
        ivl.delete();
        ivl.push_back(4); ivl.push_back(4); ivl.push_back(8); ivl.push_back(4); ivl.push_back(4);
        play(0);
        ivl.delete();
        repeat (4) ivl.push_back(3);
        play(2);

        // Saturation of both edge_count and span
        ivl.delete();
        repeat (399) ivl.push_back(3);
        play(2);

        // Randomised bursts with occasional off-pitch intervals
        for (int r = 0; r < 10; r++) begin
            n    = $urandom_range(1, 30);
            base = ($urandom_range(0, 1) == 1) ? 3 : 4;
            ivl.delete();
            for (int k = 0; k < n - 1; k++) begin
                if ($urandom_range(0, 7) == 0) ivl.push_back($urandom_range(1, 8));
                else ivl.push_back(base);
            end
            play($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
